// File: rtl/cft_int_pkg.sv
// Shared encodings for the interrupt-flag logic: microcode action codes and FSM states.
package cft_int_pkg;

  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [3:0] ACTION_STI = 4'b0011;
  localparam logic [3:0] ACTION_CLI = 4'b0100;

  // 2'b11 is unused and recovers to IDLE.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PEND = 2'b01;
  localparam logic [1:0] ST_ACK  = 2'b10;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for an asynchronous active-low request line.
// Resets every stage to 1 (inactive); output follows the input STAGES edges later.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '1;
    end else begin
      sr <= {sr[STAGES-2:0], din};
    end
  end

  assign dout = sr[STAGES-1];

endmodule

// File: rtl/int_flag_fsm.sv
// Interrupt-enable flag (fi) with delayed STI, plus the request/acknowledge FSM
// that drives the registered, active-low nirqs to the microcode sequencer.
module int_flag_fsm #(
  parameter int         SYNC_STAGES = cft_int_pkg::SYNC_STAGES_DEF,
  parameter logic [3:0] ACTION_STI  = cft_int_pkg::ACTION_STI,
  parameter logic [3:0] ACTION_CLI  = cft_int_pkg::ACTION_CLI
) (
  input  logic       clk4,
  input  logic       reset,
  input  logic [3:0] action,
  input  logic       nflagwe,
  input  logic       ibus15,
  input  logic       nirq,
  input  logic       nend,
  input  logic       ninta,
  output logic       fi,
  output logic       nirqs
);

  import cft_int_pkg::*;

  logic       nirq_sync;
  logic       irq_s;
  logic       sti_arm;
  logic       fi_nxt;
  logic       arm_nxt;
  logic [1:0] state;
  logic [1:0] state_nxt;

  irq_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk4),
    .reset(reset),
    .din  (nirq),
    .dout (nirq_sync)
  );

  assign irq_s = ~nirq_sync;

  // An STI in the same cycle as nend only arms; the arm is consumed by a later nend.
  always_comb begin
    fi_nxt  = fi;
    arm_nxt = sti_arm;
    if (state == ST_PEND && !ninta) begin
      fi_nxt = 1'b0;
    end else if (!nflagwe) begin
      fi_nxt  = ibus15;
      arm_nxt = 1'b0;
    end else if (action == ACTION_CLI) begin
      fi_nxt  = 1'b0;
      arm_nxt = 1'b0;
    end else if (action == ACTION_STI) begin
      arm_nxt = 1'b1;
    end else if (sti_arm && !nend) begin
      fi_nxt  = 1'b1;
      arm_nxt = 1'b0;
    end
  end

  // PEND looks at the post-edge fi so a CLI or flag write drops the request on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (irq_s && fi) state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (!ninta)                 state_nxt = ST_ACK;
        else if (!irq_s || !fi_nxt) state_nxt = ST_IDLE;
      end
      ST_ACK: begin
        if (ninta) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk4) begin
    if (reset) begin
      fi      <= 1'b0;
      sti_arm <= 1'b0;
      state   <= ST_IDLE;
      nirqs   <= 1'b1;
    end else begin
      fi      <= fi_nxt;
      sti_arm <= arm_nxt;
      state   <= state_nxt;
      nirqs   <= (state_nxt != ST_PEND);
    end
  end

endmodule

// File: tb/tb_int_flag_fsm.sv
// Directed bench for int_flag_fsm: a vector table for the fi/STI priority rules,
// plus hand-written sequences for synchroniser latency, acknowledge and reset corners.
module tb_int_flag_fsm;

  localparam logic [3:0] STI = 4'b0011;
  localparam logic [3:0] CLI = 4'b0100;
  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PEND = 2'b01;
  localparam logic [1:0] S_ACK  = 2'b10;

  logic       clk4 = 1'b0;
  logic       reset;
  logic [3:0] action;
  logic       nflagwe;
  logic       ibus15;
  logic       nirq;
  logic       nend;
  logic       ninta;
  logic       fi;
  logic       nirqs;

  int checks = 0;
  int errors = 0;

  int_flag_fsm #(
    .SYNC_STAGES(2),
    .ACTION_STI (STI),
    .ACTION_CLI (CLI)
  ) dut (
    .clk4   (clk4),
    .reset  (reset),
    .action (action),
    .nflagwe(nflagwe),
    .ibus15 (ibus15),
    .nirq   (nirq),
    .nend   (nend),
    .ninta  (ninta),
    .fi     (fi),
    .nirqs  (nirqs)
  );

  always #5 clk4 = ~clk4;

  typedef struct {
    string      name;
    logic [3:0] action;
    logic       nflagwe;
    logic       ibus15;
    logic       nend;
    logic       ninta;
    logic       efi;
    logic       earm;
    logic       enirqs;
    logic [1:0] est;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mkv(string n, logic [3:0] a, logic we, logic ib, logic ne,
                               logic ia, logic efi, logic earm);
    vec_t v;
    v.name = n; v.action = a; v.nflagwe = we; v.ibus15 = ib; v.nend = ne; v.ninta = ia;
    v.efi = efi; v.earm = earm; v.enirqs = 1'b1; v.est = S_IDLE;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    action = NOP; nflagwe = 1'b1; ibus15 = 1'b0; nend = 1'b1; ninta = 1'b1;
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic step();
    @(posedge clk4);
    @(negedge clk4);
  endtask

  initial begin
    reset = 1'b1; nirq = 1'b1;
    idle_inputs();

    // Reset state
    step(); step();
    chk("rst_fi", fi, 0);
    chk("rst_nirqs", nirqs, 1);
    chk("rst_state", dut.state, S_IDLE);
    chk("rst_arm", dut.sti_arm, 0);
    chk("rst_sync", dut.u_sync.sr, 2'b11);
    reset = 1'b0;

    // Request with interrupts disabled never pends
    nirq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("dis_nirqs", nirqs, 1);
      chk("dis_fi", fi, 0);
    end
    chk("dis_state", dut.state, S_IDLE);
    nirq = 1'b1;
    step(); step(); step();

    // fi / STI priority table, nirq inactive throughout
    vt[0]  = mkv("sti_same_nend",   STI, 1, 0, 0, 1, 0, 1);
    vt[1]  = mkv("armed_wait",      NOP, 1, 0, 1, 1, 0, 1);
    vt[2]  = mkv("armed_nend",      NOP, 1, 0, 0, 1, 1, 0);
    vt[3]  = mkv("cli",             CLI, 1, 0, 1, 1, 0, 0);
    vt[4]  = mkv("flagwe_over_cli", CLI, 0, 1, 1, 1, 1, 0);
    vt[5]  = mkv("nend_no_arm",     NOP, 1, 0, 0, 1, 1, 0);
    vt[6]  = mkv("flagwe_zero",     NOP, 0, 0, 1, 1, 0, 0);
    vt[7]  = mkv("sti_arm",         STI, 1, 0, 1, 1, 0, 1);
    vt[8]  = mkv("sti_rearm_nend",  STI, 1, 0, 0, 1, 0, 1);
    vt[9]  = mkv("flagwe_over_sti", STI, 0, 0, 1, 1, 0, 0);
    vt[10] = mkv("nend_disarmed",   NOP, 1, 0, 0, 1, 0, 0);
    vt[11] = mkv("inta_idle_fi0",   NOP, 1, 0, 1, 0, 0, 0);
    vt[12] = mkv("flagwe_one",      NOP, 0, 1, 1, 1, 1, 0);
    vt[13] = mkv("inta_idle_fi1",   NOP, 1, 0, 1, 0, 1, 0);
    vt[14] = mkv("sti_while_fi1",   STI, 1, 0, 1, 1, 1, 1);
    vt[15] = mkv("nend_fi_stays",   NOP, 1, 0, 0, 1, 1, 0);

    for (int i = 0; i < 16; i++) begin
      action = vt[i].action; nflagwe = vt[i].nflagwe; ibus15 = vt[i].ibus15;
      nend = vt[i].nend; ninta = vt[i].ninta;
      step();
      chk({vt[i].name, "_fi"}, fi, vt[i].efi);
      chk({vt[i].name, "_arm"}, dut.sti_arm, vt[i].earm);
      chk({vt[i].name, "_nirqs"}, nirqs, vt[i].enirqs);
      chk({vt[i].name, "_state"}, dut.state, vt[i].est);
    end
    idle_inputs();

    // fi=1: request pends SYNC_STAGES+1 edges after nirq falls, then acknowledge
    nirq = 1'b0;
    step(); chk("lat_e1", nirqs, 1);
    step(); chk("lat_e2", nirqs, 1);
    step(); chk("lat_e3", nirqs, 0);
    chk("lat_state", dut.state, S_PEND);
    ninta = 1'b0;
    step();
    chk("ack_fi", fi, 0);
    chk("ack_nirqs", nirqs, 1);
    chk("ack_state", dut.state, S_ACK);
    step();
    chk("ack_hold", dut.state, S_ACK);
    ninta = 1'b1;
    step();
    chk("ack_release", dut.state, S_IDLE);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_repend", nirqs, 1);
    end

    // Software re-enables, request re-pends, then CLI withdraws it on one edge
    nflagwe = 1'b0; ibus15 = 1'b1;
    step();
    nflagwe = 1'b1; ibus15 = 1'b0;
    chk("reen_fi", fi, 1);
    step();
    chk("repend_nirqs", nirqs, 0);
    chk("repend_state", dut.state, S_PEND);
    action = CLI;
    step();
    action = NOP;
    chk("cli_pend_fi", fi, 0);
    chk("cli_pend_nirqs", nirqs, 1);
    chk("cli_pend_state", dut.state, S_IDLE);
    step(); step();
    chk("cli_pend_stay", nirqs, 1);

    // Reset in PEND with the arm set
    nflagwe = 1'b0; ibus15 = 1'b1;
    step();
    nflagwe = 1'b1; ibus15 = 1'b0;
    step();
    chk("pend2_state", dut.state, S_PEND);
    action = STI;
    step();
    action = NOP;
    chk("pend_sti_arm", dut.sti_arm, 1);
    chk("pend_sti_state", dut.state, S_PEND);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_pend_fi", fi, 0);
    chk("rst_pend_nirqs", nirqs, 1);
    chk("rst_pend_arm", dut.sti_arm, 0);
    chk("rst_pend_state", dut.state, S_IDLE);
    nend = 1'b0;
    step();
    nend = 1'b1;
    chk("rst_nend_fi", fi, 0);

    // Withdrawal: pend (bounded wait), release nirq, IDLE after SYNC_STAGES+1 edges
    nflagwe = 1'b0; ibus15 = 1'b1;
    step();
    nflagwe = 1'b1; ibus15 = 1'b0;
    begin
      int n;
      n = 0;
      while (nirqs !== 1'b0 && n < 6) begin
        step();
        n++;
      end
      chk("wd_pend_seen", nirqs, 0);
    end
    nirq = 1'b1;
    step(); chk("wd_e1", nirqs, 0);
    step(); chk("wd_e2", nirqs, 0);
    step(); chk("wd_e3", nirqs, 1);
    chk("wd_state", dut.state, S_IDLE);
    chk("wd_fi", fi, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_flag_fsm.md
Name: int_flag_fsm

Overview:
- Interrupt-enable and interrupt-request state machine.
- Sits directly upstream of the flag unit: produces the fi flag that the flag unit drives onto ibus[15] and the front-panel fpd[7].
- Synchronises the external active-low interrupt line and decodes the STI/CLI actions that the flag unit no longer decodes.
- Tracks a pending request and runs the acknowledge handshake with the microcode sequencer.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the nirq synchroniser chain (minimum 2).
ACTION_STI, 4'b0011, action code that arms interrupt enable.
ACTION_CLI, 4'b0100, action code that clears interrupt enable.

Ports:
clk4  in  1  processor clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
action  in  4  microcode action field.
nflagwe  in  1  active-low flag write strobe (waddr 01101/01110), sampled on the clock edge.
ibus15  in  1  ibus[15], the fi bit of a flag write.
nirq  in  1  external interrupt request; active-low, level-sensitive, asynchronous.
nend  in  1  active-low end-of-instruction marker, one clock wide.
ninta  in  1  active-low interrupt acknowledge from the microcode.
fi  out  1  interrupt-enable flag, goes to flag_unit.fi.
nirqs  out  1  active-low, registered interrupt-pending indication to the microcode.

Behaviour:
- Reset (sampled high at an edge):
  - fi=0, nirqs=1, state=IDLE, sti_arm=0.
  - All synchroniser flops =1 (inactive).
  - Reset overrides every other input in that cycle.
- Synchroniser:
  - nirq passes through SYNC_STAGES flops.
  - irq_s = ~last stage.
  - A change on nirq is visible to the FSM SYNC_STAGES edges later.
- fi update, highest priority first:
  1. reset: fi<=0.
  2. State PEND with ninta=0: fi<=0.
  3. nflagwe=0: fi<=ibus15; sti_arm<=0.
  4. action==ACTION_CLI: fi<=0; sti_arm<=0.
  5. action==ACTION_STI: sti_arm<=1; fi unchanged.
  6. sti_arm=1 and nend=0: fi<=1; sti_arm<=0.
- STI delay: the arm is set in the edge where STI is sampled. The nend of that same cycle does not consume it, so fi rises at the first nend strictly after the STI cycle. This gives a one-instruction enable shadow.
- STI while already armed: stays armed, no other effect.
- STI while fi=1: harmless; arm is set and consumed at the next nend with fi staying 1.
- FSM states: IDLE, PEND, ACK (encoding in package).
  - IDLE: if irq_s && fi → PEND.
  - PEND: nirqs=0.
    - ninta=0 → ACK (fi cleared per priority 2).
    - Else if !irq_s or !fi → IDLE (request withdrawn or CLI/flag write); nirqs=1 on the same edge.
  - ACK: nirqs=1; stays in ACK while ninta=0; ninta=1 → IDLE.
  - A still-asserted irq re-pends only after software re-enables fi.
- nirqs is registered: low exactly while state==PEND. Latency from nirq falling (fi=1) to nirqs low is SYNC_STAGES+1 edges.
- ninta=0 outside PEND: ignored, no effect on fi or state.
- nflagwe=0 with CLI/STI in the same cycle: the flag write wins and the arm is cleared.
- Reset mid-PEND or mid-ACK: next edge gives IDLE, fi=0, nirqs=1.

Decomposition:
- Shared package (cft_int_pkg): ACTION_STI/ACTION_CLI codes, state encodings IDLE=2'b00, PEND=2'b01, ACK=2'b10. 2'b11 is illegal and recovers to IDLE.
- Natural sub-module: irq_sync.
  - Parameterised SYNC_STAGES synchroniser with synchronous reset to 1.
  - Reused later for the front-panel request lines.

Test Plan:
1. Reset held 2 clocks, then nirq=0 with fi=0 → nirqs stays 1 for 20 clocks, fi=0, state IDLE.
2. action=0011, then nend=0 in the same cycle → fi stays 0. A second nend two clocks later → fi=1 after that edge.
3. fi=1, nirq falls at t0 → nirqs=0 after 3 edges. ninta=0 one clock → fi=0, nirqs=1, state ACK. ninta=1 → IDLE. nirq still 0 → nirqs stays 1.
4. State PEND, action=0100 → next edge fi=0, nirqs=1, state IDLE.
5. nflagwe=0 with ibus15=1 and action=0100 in the same cycle → fi=1, sti_arm=0. Then nflagwe=0 with ibus15=0 → fi=0.
6. Reset asserted while in PEND with sti_arm=1 → next edge fi=0, nirqs=1, sti_arm=0. A subsequent nend does not set fi.
